// File: rtl/direction_queue.sv
// direction_queue: synchronizes and edge-detects direction buttons, filters illegal turns,
// and queues accepted turns for release one per game tick.
module direction_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = 2'd3
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic                       s_reset,
  input  logic [3:0]                 direction_pb,
  input  logic                       tick,
  output logic [1:0]                 dir,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [3:0]    sync1_q, sync2_q, prev_q, evt;
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic [1:0]    dir_q, cand, ref_dir;
  logic          drop_q, has_evt, reject, push, pop;
  // Only the highest-priority new press is considered; lower ones vanish silently.
  always_comb begin
    evt     = sync2_q & ~prev_q;
    has_evt = |evt;
    cand    = evt[3] ? 2'd0 : evt[2] ? 2'd1 : evt[1] ? 2'd2 : 2'd3;
    ref_dir = (count_q != '0) ? mem_q[wr_q - AW'(1)] : dir_q;
    reject  = (cand == ref_dir) || (cand == {ref_dir[1], ~ref_dir[0]}) || (count_q == CW'(DEPTH));
    push    = has_evt && !reject;
    pop     = tick && (count_q != '0);
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      dir_q   <= INIT_DIR;
      drop_q  <= 1'b0;
    end else begin
      sync1_q <= direction_pb;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (s_reset) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
        dir_q   <= INIT_DIR;
        drop_q  <= 1'b0;
      end else begin
        drop_q <= has_evt && reject;
        if (push) begin
          mem_q[wr_q] <= cand;
          wr_q        <= wr_q + AW'(1);
        end
        if (pop) begin
          dir_q <= mem_q[rd_q];
          rd_q  <= rd_q + AW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end
  assign dir   = dir_q;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign drop  = drop_q;
endmodule

// File: tb/tb_direction_queue.sv
// tb_direction_queue: directed and random stimulus checked against a queue-based turn model.
module tb_direction_queue;
  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       s_reset = 1'b0;
  logic [3:0] direction_pb = '0;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic [2:0] count;
  logic       empty, full, drop;
  int checks = 0;
  int errors = 0;

  logic [1:0] q[$];
  int         mdir = 3;
  int         mdrop = 0;
  logic [3:0] h1 = '0, h2 = '0, h3 = '0;

  direction_queue #(.DEPTH(4), .INIT_DIR(2'd3)) dut (
    .clk(clk), .nRst(nRst), .s_reset(s_reset), .direction_pb(direction_pb),
    .tick(tick), .dir(dir), .count(count), .empty(empty), .full(full), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdir = 3;
    mdrop = 0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  // A button press becomes visible two edges after it is sampled; turns are checked
  // against the last queued heading, or the committed one when nothing is queued.
  task automatic model_edge();
    logic [3:0] ev;
    int cand, refd, n;
    bit rej;
    ev = h2 & ~h3;
    cand = -1;
    for (int i = 3; i >= 0; i--) if (ev[i] && cand < 0) cand = 3 - i;
    n = q.size();
    if (s_reset) begin
      q.delete();
      mdir = 3;
      mdrop = 0;
    end else begin
      refd = (n > 0) ? int'(q[$]) : mdir;
      rej = (cand == refd) || ((cand ^ refd) == 1) || (n == 4);
      mdrop = (cand >= 0 && rej) ? 1 : 0;
      if (tick && n > 0) mdir = int'(q.pop_front());
      if (cand >= 0 && !rej) q.push_back(2'(cand));
    end
    h3 = h2; h2 = h1; h1 = direction_pb;
  endtask

  task automatic check_all();
    chk("dir", int'(dir), mdir);
    chk("count", int'(count), q.size());
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full", int'(full), int'(q.size() == 4));
    chk("drop", int'(drop), mdrop);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic press(input logic [3:0] b, input int hold = 4, input int gap = 3);
    direction_pb = b;
    step(hold);
    direction_pb = '0;
    step(gap);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  initial begin
    #12;
    model_reset();
    chk("rst_dir", int'(dir), 3);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    nRst = 1'b1;
    step(3);
    // single press held: one push three edges after the rise
    direction_pb = 4'b1000;
    step(2);
    chk("up_not_yet", int'(count), 0);
    step();
    chk("up_pushed", int'(count), 1);
    step(7);
    direction_pb = '0;
    step(3);
    chk("up_once", int'(count), 1);
    do_tick();
    chk("up_commit", int'(dir), 0);
    chk("up_empty", int'(empty), 1);
    // filtering: get to RIGHT, then same/opposite presses
    press(4'b0001);
    do_tick();
    chk("right_dir", int'(dir), 3);
    direction_pb = 4'b0010;
    step(3);
    chk("left_drop", int'(drop), 1);
    chk("left_count", int'(count), 0);
    step();
    chk("drop_one_cycle", int'(drop), 0);
    direction_pb = '0;
    step(3);
    press(4'b0001);
    press(4'b1000);
    press(4'b0100);
    chk("down_vs_tail_count", int'(count), 1);
    do_tick();
    // fill and overflow
    press(4'b0001);
    do_tick();
    press(4'b1000);
    press(4'b0010);
    press(4'b0100);
    press(4'b0001);
    chk("fill_count", int'(count), 4);
    chk("fill_full", int'(full), 1);
    press(4'b1000);
    chk("overflow_count", int'(count), 4);
    direction_pb = 4'b1000;
    step(2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("overflow_tick_drop", int'(drop), 1);
    chk("overflow_tick_count", int'(count), 3);
    chk("overflow_tick_dir", int'(dir), 0);
    direction_pb = '0;
    step(3);
    do_tick();
    chk("drain_dir1", int'(dir), 2);
    do_tick();
    chk("drain_dir2", int'(dir), 1);
    do_tick();
    chk("drain_dir3", int'(dir), 3);
    chk("drain_empty", int'(empty), 1);
    // simultaneous events
    press(4'b1010);
    chk("simul_count", int'(count), 1);
    do_tick();
    chk("simul_dir", int'(dir), 0);
    // push coinciding with tick on an empty queue
    direction_pb = 4'b0010;
    step(2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("pushpop_count", int'(count), 1);
    chk("pushpop_dir", int'(dir), 0);
    direction_pb = '0;
    step(2);
    do_tick();
    chk("pushpop_commit", int'(dir), 2);
    // restart with queued entries, a tick and a new press in the same cycle
    press(4'b1000);
    press(4'b0001);
    press(4'b0100);
    chk("pre_restart_count", int'(count), 3);
    direction_pb = 4'b0010;
    step(2);
    s_reset = 1'b1;
    tick = 1'b1;
    step();
    s_reset = 1'b0;
    tick = 1'b0;
    chk("restart_count", int'(count), 0);
    chk("restart_dir", int'(dir), 3);
    chk("restart_drop", int'(drop), 0);
    step(6);
    chk("held_no_event", int'(count), 0);
    direction_pb = '0;
    step(3);
    // asynchronous reset mid-run with 3 queued
    press(4'b1000);
    press(4'b0010);
    press(4'b0100);
    chk("pre_nrst_count", int'(count), 3);
    #2;
    nRst = 1'b0;
    #1;
    model_reset();
    chk("nrst_dir", int'(dir), 3);
    chk("nrst_count", int'(count), 0);
    chk("nrst_empty", int'(empty), 1);
    chk("nrst_full", int'(full), 0);
    chk("nrst_drop", int'(drop), 0);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
    step(5);
    // random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) direction_pb = 4'($urandom_range(0, 15));
      tick = ($urandom_range(0, 3) == 0);
      s_reset = ($urandom_range(0, 59) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/direction_queue.md
# direction_queue

Input-side stage directly upstream of `snake_body_controller`. Turns the four raw direction push-buttons into a stream of legal turn commands. Each new press is synchronized, edge-detected and filtered against reversals and duplicates, then held in a small FIFO. The committed heading is released one entry per game-step tick, so fast multi-key inputs between steps are not lost.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `INIT_DIR`, 2'd3: heading after reset or restart (RIGHT).
- `clk` input, 1: system clock.
- `nRst` input, 1: reset, asynchronous, active-low.
- `s_reset` input, 1: synchronous game restart (the `sync` strobe).
- `direction_pb` input, 4: raw buttons; [3]=UP, [2]=DOWN, [1]=LEFT, [0]=RIGHT.
- `tick` input, 1: one-cycle game-step strobe from the body controller.
- `dir` output, 2: committed heading; 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
- `count` output, $clog2(DEPTH+1): number of queued turns.
- `empty` output, 1: count==0.
- `full` output, 1: count==DEPTH.
- `drop` output, 1: one-cycle pulse when a press is rejected.

Clock is one domain; reset is asynchronous, active-low (`nRst`).

## Operation
- **Synchronizer and edge detect:** each button passes through a 2-flop synchronizer, then a registered previous-value flop. An event is a synchronized 0→1 transition; a held button produces exactly one event.
- **Simultaneous events:** if events occur on several buttons in the same cycle, only the highest priority is considered (UP>DOWN>LEFT>RIGHT). The others are discarded silently, with no `drop`.
- **Reference heading:**
  - FIFO tail entry if count>0, else `dir`.
  - Evaluated on pre-cycle state.
- **Rejection:** the candidate is rejected when any of these hold:
  - it equals the reference heading;
  - it is the opposite of the reference heading (opposite = {d[1], ~d[0]});
  - count==DEPTH on pre-cycle state, even if `tick` pops in the same cycle.
- **Reject or accept:**
  - Rejected candidate → `drop`=1 for one cycle.
  - Accepted candidate → written at the write pointer; count increments.
- **Pop:** `tick` with count>0 (pre-cycle) loads `dir` from the head and decrements count. `tick` with an empty FIFO leaves `dir` unchanged.
- **Push and pop in the same cycle:**
  - Both occur; count is unchanged.
  - If the FIFO was empty, the pushed entry is not popped in that cycle; it is consumed at the next `tick`.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count saturates by construction, never beyond 0..DEPTH.
- **`s_reset` priority:** highest synchronous priority. It:
  - clears count and pointers;
  - sets `dir`=INIT_DIR and `drop`=0;
  - blocks push and pop that cycle.
  - Synchronizer and previous-value flops keep running, so a button held across the restart creates no event.
- **`nRst` low (any time, including mid-operation):**
  - all flops clear immediately: synchronizers and previous-value flops to 0;
  - `dir`=INIT_DIR, count=0, `empty`=1, `full`=0, `drop`=0.

## Timing
- `direction_pb` rising before edge E0 gives:
  - sync1 high after E0;
  - sync2 high after E1;
  - event decoded combinationally in cycle E1→E2;
  - push and `drop` registered at E2, so count/`drop` are visible 3 edges after the input rise.
- `tick` high in the cycle before edge Et → `dir` updates at Et.
- `empty`/`full` are decoded from registered count; they have no extra latency.
- `drop` is high for exactly one cycle per rejected press.
- `s_reset` sampled at edge Es → all state is at restart values after Es.

## Test plan
- **Reset:** assert `nRst`=0 mid-run with 3 entries queued → immediately `dir`=3, count=0, `empty`=1, `full`=0, `drop`=0; these hold after release with no input.
- **Single press:** press UP held 10 cycles from `dir`=3 → count goes 0→1 three edges after the rise, with only one push. Then `tick` → `dir`=0, count=0, `empty`=1.
- **Filtering:**
  - From `dir`=3, press LEFT → `drop` pulses, count stays 0.
  - Press RIGHT → `drop` pulses.
  - Queue UP (count=1), then press DOWN → `drop`, because it is opposite of the tail.
- **Fill and overflow (DEPTH=4):**
  - Press UP, LEFT, DOWN, RIGHT → count=4, `full`=1.
  - Press UP → `drop`, count stays 4.
  - Press UP again in the same cycle as a `tick` → still `drop`, count 3.
  - Further ticks → `dir` sequence 0, 2, 1, 3, then `empty`=1.
- **Simultaneous events:**
  - UP and LEFT rise together from `dir`=3 → only UP queued, no `drop`.
  - Empty FIFO, push coincides with `tick` → count=1 after, `dir` unchanged; the next `tick` commits it.
- **Restart:** with 3 entries queued, pulse `s_reset` together with `tick` and a new press → count=0, `dir`=3, `drop`=0. A button held through the restart produces no later event.
